// File: rtl/dmem_wbuf.sv
// Data-memory write buffer: a DEPTH-entry store FIFO that drains into backing
// memory and forwards buffered data to loads. Define DMEM_WBUF_COALESCE_EN to merge stores into pending non-head entries.
module dmem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        empty,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic             full, enq, deq;
  logic             coalesce_hit;
  logic [PTR_W-1:0] coalesce_idx;
  logic [29:0]      word;
  logic             unused_lsbs;

  assign word        = aluout[31:2];
  assign unused_lsbs = ^aluout[1:0];

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign mem_wvalid = ~empty;
  assign deq        = mem_wvalid & mem_wready;
  // A dequeue in the same cycle frees a slot only after the edge, so stall ignores it.
  assign stall      = memwrite & full & ~coalesce_hit;
  assign enq        = memwrite & ~full & ~coalesce_hit;

  assign mem_waddr = {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = data_q[rd_ptr];
  assign mem_raddr = {word, 2'b00};

  // Walk oldest to youngest so the youngest matching entry wins; the head is
  // included even while it is being handed to memory this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    readdata = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_q[rd_ptr + PTR_W'(i)] == word))
        readdata = data_q[rd_ptr + PTR_W'(i)];
    end
  end

`ifdef DMEM_WBUF_COALESCE_EN
  // The head may already be on the memory bus, so the search starts one past it.
  always_comb begin
    coalesce_hit = 1'b0;
    coalesce_idx = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (memwrite && (CNT_W'(i) < count) && (addr_q[rd_ptr + PTR_W'(i)] == word)) begin
        coalesce_hit = 1'b1;
        coalesce_idx = rd_ptr + PTR_W'(i);
      end
    end
  end
`else
  assign coalesce_hit = 1'b0;
  assign coalesce_idx = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: the entry array is reset on purpose so the bus reads zero after reset;
      // most storage arrays should be left unreset.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (enq) begin
        addr_q[wr_ptr] <= word;
        data_q[wr_ptr] <= writedata;
        wr_ptr         <= wr_ptr + 1'b1;
      end else if (coalesce_hit) begin
        data_q[coalesce_idx] <= writedata;
      end

      if (deq) rd_ptr <= rd_ptr + 1'b1;

      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The core never issues a load and a store in the same cycle.
  a_no_load_store: assert property (@(posedge clk) disable iff (!reset) !(memread && memwrite));

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: a scoreboard queue holds stores in program order
// and is popped on every write handshake; loads, stall and reset are checked inline.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, memread;
  logic [31:0] aluout, writedata;
  logic [31:0] readdata;
  logic        stall, empty, mem_wvalid, mem_wready;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  dmem_wbuf #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .memread    (memread),
    .aluout     (aluout),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .empty      (empty),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Handshakes complete on the next rising edge; inputs only change just after
  // rising edges, so the falling edge sees exactly what the edge will see.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_wvalid === 1'b1 && mem_wready === 1'b1) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=0x%08h data=0x%08h expected no write",
               mem_waddr, mem_wdata);
      end
      if (sb.size() > 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        check("wr_addr", mem_waddr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memwrite = 1'b0;
    memread  = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memread   = 1'b0;
    memwrite  = 1'b1;
    aluout    = a;
    writedata = d;
    sb.push_back({a & 32'hFFFF_FFFC, d});
    tick();
  endtask

  task automatic drain();
    idle();
    mem_wready = 1'b1;
    for (int i = 0; i < 40 && empty !== 1'b1; i++) tick();
    check("drain_empty", 32'(empty), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    mem_wready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    aluout     = '0;
    writedata  = '0;
    mem_wready = 1'b0;
    mem_rdata  = 32'h0000_1234;

    // Reset state, with a store strobe already presented.
    #3;
    memwrite  = 1'b1;
    aluout    = 32'h10;
    writedata = 32'hAAAA_0001;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wvalid", 32'(mem_wvalid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_waddr", mem_waddr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_readdata", readdata, 32'h0000_1234);

    // Release reset; the very first edge accepts the store.
    @(negedge clk);
    reset = 1'b1;
    sb.push_back({32'h10, 32'hAAAA_0001});
    tick();
    store(32'h14, 32'hAAAA_0002);
    idle();
    @(negedge clk);
    check("two_count", 32'(dut.count), 32'd2);
    check("two_wvalid", 32'(mem_wvalid), 32'd1);
    check("raddr", mem_raddr, 32'h14);
    for (int c = 0; c < 3; c++) begin
      check("hold_waddr", mem_waddr, 32'h10);
      check("hold_wdata", mem_wdata, 32'hAAAA_0001);
      tick();
      @(negedge clk);
    end
    drain();

    // Full buffer: fifth store stalls until a single handshake frees a slot.
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'h3400_0000 + 32'(i));
    memwrite  = 1'b1;
    aluout    = 32'h20;
    writedata = 32'h2020_2020;
    @(negedge clk);
    check("full_stall0", 32'(stall), 32'd1);
    tick();
    @(negedge clk);
    check("full_stall1", 32'(stall), 32'd1);
    check("full_count", 32'(dut.count), 32'd4);
    tick();
    mem_wready = 1'b1;
    @(negedge clk);
    check("stall_during_deq", 32'(stall), 32'd1);
    tick();
    mem_wready = 1'b0;
    @(negedge clk);
    check("stall_dropped", 32'(stall), 32'd0);
    sb.push_back({32'h20, 32'h2020_2020});
    tick();
    idle();
    @(negedge clk);
    check("refill_count", 32'(dut.count), 32'd4);
    drain();

    // Forwarding: youngest match wins, word-granular, misses go to memory.
    store(32'h40, 32'h1);
    store(32'h40, 32'h2);
    idle();
    memread   = 1'b1;
    mem_rdata = 32'h0000_DEAD;
    aluout    = 32'h40;
    @(negedge clk);
    check("fwd_young", readdata, 32'h2);
    aluout = 32'h43;
    #1;
    check("fwd_lsb_ignored", readdata, 32'h2);
    aluout = 32'h44;
    #1;
    check("fwd_miss", readdata, 32'h0000_DEAD);
    tick();
    idle();
    drain();

    // Forwarding from the head in the cycle it is dequeued.
    store(32'h50, 32'h77);
    idle();
    memread    = 1'b1;
    aluout     = 32'h50;
    mem_wready = 1'b1;
    @(negedge clk);
    check("fwd_head_deq", readdata, 32'h77);
    tick();
    idle();
    mem_wready = 1'b0;
    @(negedge clk);
    check("fwd_after_deq", readdata, 32'h0000_DEAD);
    check("after_deq_empty", 32'(empty), 32'd1);

    // Streaming: memory always ready, one store per cycle never stalls.
    tick();
    mem_wready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      memwrite  = 1'b1;
      aluout    = 32'h200 + 32'(4 * i);
      writedata = 32'(i);
      @(negedge clk);
      check("stream_stall", 32'(stall), 32'd0);
      sb.push_back({32'h200 + 32'(4 * i), 32'(i)});
      tick();
    end
    drain();

    // Store to an address already pending behind the head of a full buffer.
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hC000_0000 + 32'(i));
    memwrite  = 1'b1;
    aluout    = 32'h8;
    writedata = 32'h55;
    @(negedge clk);
`ifdef DMEM_WBUF_COALESCE_EN
    check("coal_stall", 32'(stall), 32'd0);
    sb[2] = {32'h8, 32'h55};
    tick();
    idle();
    @(negedge clk);
    check("coal_count", 32'(dut.count), 32'd4);
`else
    check("nocoal_stall", 32'(stall), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("nocoal_count", 32'(dut.count), 32'd4);
`endif
    drain();

    // Reset mid-drain discards everything and issues no further writes.
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4 * i), 32'h5000_0000 + 32'(i));
    idle();
    mem_wready = 1'b1;
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_wvalid", 32'(mem_wvalid), 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      check("post_rst_wvalid", 32'(mem_wvalid), 32'd0);
    end
    check("post_rst_sb", 32'(sb.size()), 32'd0);
    mem_wready = 1'b0;

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered stores, power of two, >= 2.
REQ-002 The block SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-low reset (0 = asserted).
REQ-004 The block SHALL have port memwrite  in  1  core store strobe.
REQ-005 The block SHALL have port memread  in  1  core load strobe.
REQ-006 The block SHALL have port aluout  in  32  core byte address; bits [1:0] ignored.
REQ-007 The block SHALL have port writedata  in  32  core store data.
REQ-008 The block SHALL have port readdata  out  32  load data to core, combinational.
REQ-009 The block SHALL have port stall  out  1  core must hold PC and instruction.
REQ-010 The block SHALL have port empty  out  1  no store pending, for fence/halt.
REQ-011 The block SHALL have port mem_wvalid  out  1  backing-memory write request valid.
REQ-012 The block SHALL have port mem_wready  in  1  backing memory accepts write.
REQ-013 The block SHALL have port mem_waddr  out  32  head entry word address, bits [1:0] = 0.
REQ-014 The block SHALL have port mem_wdata  out  32  head entry data.
REQ-015 The block SHALL have port mem_raddr  out  32  equal to {aluout[31:2],2'b00}.
REQ-016 The block SHALL have port mem_rdata  in  32  backing-memory combinational read data.

Function
REQ-017 The block SHALL hold a circular FIFO of DEPTH {addr[31:2], data} entries with rd_ptr, wr_ptr and count 0..DEPTH, pointers wrapping modulo DEPTH.
REQ-018 The block SHALL enqueue {aluout[31:2], writedata} at wr_ptr on a rising edge when memwrite=1 and stall=0.
REQ-019 stall SHALL equal memwrite & full & ~coalesce_hit (coalesce_hit is 0 when REQ-030 is disabled); full = (count==DEPTH); a dequeue in the same cycle does not clear stall.
REQ-020 mem_wvalid SHALL equal ~empty; mem_waddr/mem_wdata SHALL present the head entry.
REQ-021 A dequeue SHALL occur on a rising edge where mem_wvalid & mem_wready; head SHALL remain stable while mem_wvalid=1 and mem_wready=0.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-023 Loads SHALL forward: readdata = data of youngest entry whose addr matches aluout[31:2], else mem_rdata.
REQ-024 Forwarding SHALL include the head entry in the cycle it is dequeued.
REQ-025 readdata SHALL be computed regardless of memread; memread is only used for bounds of assertions.
REQ-026 Stores SHALL reach backing memory in program order; latency from enqueue to mem_wvalid presentation of an entry is (entries ahead of it) handshakes, minimum one cycle.

Reset
REQ-027 On reset=0 the block SHALL asynchronously clear count, rd_ptr, wr_ptr and entry contents; outputs: empty=1, mem_wvalid=0, stall=0, mem_waddr=0, mem_wdata=0.
REQ-028 Reset asserted mid-drain SHALL discard all pending stores; an in-flight handshake is not completed.
REQ-029 After reset release, the first rising edge SHALL accept a store.

Configuration
REQ-030 With DMEM_WBUF_COALESCE_EN defined, a store whose word address matches any valid non-head entry SHALL overwrite the youngest such entry's data, not allocate, and not stall even when full (coalesce_hit=1).
REQ-031 Without DMEM_WBUF_COALESCE_EN, every accepted store SHALL allocate a new entry; coalesce_hit is constant 0.
REQ-032 The head entry SHALL never be coalesced in either configuration.

Verification
REQ-033 Reset, then stores 0x10<-0xAAAA0001, 0x14<-0xAAAA0002 with mem_wready=0 -> count=2, mem_wvalid=1, mem_waddr=0x10 held stable.
REQ-034 Four stores with mem_wready=0, fifth store 0x20 -> stall=1 until one mem_wready pulse; 0x20 enqueued the edge after stall drops.
REQ-035 Stores 0x40<-1 then 0x40<-2, load 0x40 with mem_rdata=0xDEAD -> readdata=2; load 0x44 -> readdata=0xDEAD.
REQ-036 mem_wready=1 continuously, store every cycle for 10 cycles -> stall never 1, mem_waddr sequence matches program order.
REQ-037 COALESCE_EN: fill 0x0,0x4,0x8,0xC, store 0x8<-0x55 -> stall=0, count=4, drained data at 0x8 is 0x55; without macro -> stall=1.
REQ-038 Assert reset with 3 entries pending and mem_wready=1 -> empty=1, mem_wvalid=0 immediately, no further writes issued.
